// File: rtl/pipe_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : RAW stall / branch flush controller for the IF/ID/EX/WB pipeline.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W     = 6,
    parameter int PIPE_DEPTH     = 2,
    parameter bit ZERO_REG_FIXED = 1'b1,
    parameter int STAT_W         = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  id_valid,
    input  logic                  id_regwrt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  wb_branch_taken,
    output logic                  pc_hold,
    output logic                  ifid_hold,
    output logic                  idex_bubble,
    output logic                  flush_younger,
    output logic [1:0]            state,
    output logic [STAT_W-1:0]     stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    state_t                  state_q, state_d;
    logic [PIPE_DEPTH-1:0]   v_q, v_d;
    logic [REG_ADDR_W-1:0]   rd_q [PIPE_DEPTH];
    logic [REG_ADDR_W-1:0]   rd_d [PIPE_DEPTH];
    logic [STAT_W-1:0]       stall_cnt_q, stall_cnt_d;

    logic [PIPE_DEPTH-1:0]   w_match_rs;
    logic [PIPE_DEPTH-1:0]   w_match_rt;
    logic                    w_rs_zero_ign;
    logic                    w_rt_zero_ign;
    logic                    w_hazard;
    logic                    w_stall;

    assign w_rs_zero_ign = ZERO_REG_FIXED && (id_rs == '0);
    assign w_rt_zero_ign = ZERO_REG_FIXED && (id_rt == '0);

    // The WB entry still counts: the register file is not write-through.
    for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_match
        assign w_match_rs[i] = v_q[i] && (rd_q[i] == id_rs) && !w_rs_zero_ign;
        assign w_match_rt[i] = v_q[i] && (rd_q[i] == id_rt) && !w_rt_zero_ign;
    end

    // id_valid leads each term so undriven operands cannot reach the holds.
    assign w_hazard = id_valid && (state_q != ST_FLUSH) &&
                      ((id_uses_rs && (|w_match_rs)) || (id_uses_rt && (|w_match_rt)));
    assign w_stall  = w_hazard && !wb_branch_taken;

    assign pc_hold       = w_stall;
    assign ifid_hold     = w_stall;
    assign idex_bubble   = w_stall;
    assign flush_younger = wb_branch_taken;
    assign state         = state_q;
    assign stall_cnt     = stall_cnt_q;

    always_comb begin
        v_d  = v_q;
        rd_d = rd_q;
        if (wb_branch_taken) begin
            v_d = '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                rd_d[i] = '0;
            end
        end else begin
            v_d[0]  = w_stall ? 1'b0 : (id_valid && id_regwrt);
            rd_d[0] = w_stall ? '0 : id_rd;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                v_d[i]  = v_q[i-1];
                rd_d[i] = rd_q[i-1];
            end
        end
    end

    always_comb begin
        state_d = ST_RUN;
        if (wb_branch_taken) begin
            state_d = ST_FLUSH;
        end else if (w_hazard) begin
            state_d = ST_STALL;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (w_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            v_q         <= '0;
            stall_cnt_q <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                rd_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            v_q         <= v_d;
            rd_q        <= rd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and flush controller for the IF/ID/EX/WB pipeline. Successor to the fixed, hazard-free buffer chain; generalised in register-address width and in the number of in-flight stages.
- Tracks destination tags of instructions between ID and WB. Stalls IF/ID when a source operand is still pending. Flushes younger stages when WB resolves a taken branch or jump.
- Sits beside the ID stage. Drives hold/bubble/flush inputs of pc_register and the inter-stage buffers.

Parameters:
- REG_ADDR_W, 6, register address width (rd/rs/rt).
- PIPE_DEPTH, 2, tracked stages after ID up to and including WB (EX, WB); legal range 1..8.
- ZERO_REG_FIXED, 1, when 1, register 0 never creates a hazard.
- STAT_W, 16, width of the stall statistics counter.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_regwrt  in  1  ID instruction writes rd (control unit regWrt)
- id_rd  in  REG_ADDR_W  ID destination
- id_rs  in  REG_ADDR_W  ID source 1
- id_rt  in  REG_ADDR_W  ID source 2
- id_uses_rs  in  1  rs is read
- id_uses_rt  in  1  rt is read
- wb_branch_taken  in  1  WB branchControl (branch/jump resolved taken)
- pc_hold  out  1  pc_register keeps value
- ifid_hold  out  1  IF/ID buffer keeps value
- idex_bubble  out  1  ID/EX buffer loads all-zero control
- flush_younger  out  1  IF/ID, ID/EX, EX/WB load bubbles
- state  out  2  00 RUN, 01 STALL, 10 FLUSH
- stall_cnt  out  STAT_W  saturating count of stall cycles

Behaviour:
- Tag pipe: PIPE_DEPTH entries {v, rd}. Entry 0 is EX; entry PIPE_DEPTH-1 is WB.
- Each edge, entry i shifts to i+1. The WB entry retires.
- Entry 0 load rule:
  - No stall, no flush: loads {id_valid & id_regwrt, id_rd}.
  - Stall: loads {0, 0} (bubble).
  - Flush: all entries, including entry 0, load {0, 0}.
- Register file is not write-through. An entry in WB still counts as pending, so a dependent instruction waits until the producer has retired.
- Hazard (combinational), requires id_valid and state != FLUSH:
  - hz_rs = id_uses_rs & any(v[i] & rd[i]==id_rs).
  - hz_rt = id_uses_rt & any(v[i] & rd[i]==id_rt).
  - If ZERO_REG_FIXED, matches on address 0 are ignored.
- Outputs (combinational from state and inputs):
  - stall = hazard & ~wb_branch_taken.
  - pc_hold = ifid_hold = idex_bubble = stall.
  - flush_younger = wb_branch_taken. Flush has priority over stall.
- FSM, registered, one transition per edge, flush evaluated first:
  - RUN: wb_branch_taken -> FLUSH; else hazard -> STALL; else RUN.
  - STALL: wb_branch_taken -> FLUSH; else hazard -> STALL; else RUN.
  - FLUSH: lasts exactly 1 cycle. Hazard detection is suppressed because IF/ID holds a bubble. Next state: wb_branch_taken -> FLUSH, else RUN.
- Maximum stall per dependency is PIPE_DEPTH cycles.
- stall_cnt increments on each edge where stall=1 and saturates at all-ones. It is not cleared by flush.
- Reset (asynchronous, any time including mid-stall or mid-flush):
  - state = RUN; all v = 0, all rd = 0; stall_cnt = 0.
  - Outputs therefore reset to pc_hold = ifid_hold = idex_bubble = 0. flush_younger follows wb_branch_taken.
- Simultaneous hazard and taken branch: only the flush acts; the stall counter is not incremented.
- id_valid = 0: no hazard, and no tag is inserted.
- X on inputs while id_valid = 0 must not propagate to the hold outputs.

Test Plan:
- Reset mid-STALL (reset_n low for 3 ns between edges) -> state = 00, pc_hold = 0, stall_cnt = 0 immediately, without a clock edge.
- Back-to-back RAW: instruction A (rd = 5, regwrt) then B (rs = 5, uses_rs), PIPE_DEPTH = 2 -> pc_hold high for exactly 2 cycles, idex_bubble high for 2 cycles, stall_cnt = 2, B issues on the 3rd cycle.
- Register 0: A (rd = 0, regwrt) then B (rt = 0, uses_rt) -> no stall with ZERO_REG_FIXED = 1. With ZERO_REG_FIXED = 0 -> 2 stall cycles.
- Branch during stall: a hazard is active and wb_branch_taken = 1 in the same cycle -> flush_younger = 1, pc_hold = 0, next state = FLUSH, all tags cleared, stall_cnt unchanged. The following cycle returns to RUN with no stall.
- Non-dependent stream: 10 instructions with distinct rd/rs (e.g. rd = i, rs = i + 20) -> pc_hold never asserted, state stays RUN.
- PIPE_DEPTH = 4, STAT_W = 2, repeated RAW pairs -> each pair stalls for 4 cycles, and stall_cnt saturates at 3.
